// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetcher feeding a small
// in-order instruction queue, with redirect flush and ebreak halt.
//
// state  | meaning
// S_REQ  | may issue the next fetch at fetch_pc
// S_WAIT | one request in flight, waiting for its response
// S_HALT | ebreak fetched; no more requests, queue still drains
module ifetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [31:0]     resp_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [31:0]   EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] fetch_pc, fetch_pc_next;
    logic [XLEN-1:0] inflight_pc, inflight_pc_next;
    logic            drop, drop_next;
    logic [XLEN-1:0] redirect_aligned;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            push, pop, flush, issue;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    assign req_addr         = fetch_pc & ~XLEN'(3);
    assign out_valid        = (count != '0);
    assign out_pc           = pc_mem[rd_ptr];
    assign out_inst         = inst_mem[rd_ptr];
    assign halted           = (state == S_HALT);
    assign pop              = out_valid && out_ready;

    // A redirect owns the cycle: no request goes out while the PC is being replaced.
    assign req_valid = (state == S_REQ) && (count < FULL) && !redirect && !rst;
    assign issue     = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            drop        <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            inflight_pc <= inflight_pc_next;
            drop        <= drop_next;
        end
    end

    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        inflight_pc_next = inflight_pc;
        drop_next        = drop;
        push             = 1'b0;
        flush            = 1'b0;
        unique case (state)
            S_REQ: begin
                if (redirect) begin
                    flush         = 1'b1;
                    fetch_pc_next = redirect_aligned;
                end else if (issue) begin
                    inflight_pc_next = fetch_pc;
                    fetch_pc_next    = fetch_pc + XLEN'(4);
                    state_next       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    flush         = 1'b1;
                    fetch_pc_next = redirect_aligned;
                    // A response landing in the redirect cycle is stale; otherwise remember to drop it.
                    if (resp_valid) begin
                        drop_next  = 1'b0;
                        state_next = S_REQ;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (resp_valid) begin
                    drop_next  = 1'b0;
                    state_next = S_REQ;
                    if (!drop) begin
                        push = 1'b1;
                        if (resp_inst == EBREAK) state_next = S_HALT;
                    end
                end
            end
            S_HALT: begin
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            inst_mem[wr_ptr] <= resp_inst;
        end
    end

endmodule
